// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch stage and its neighbours.
//   RESET_PC_DEFAULT : byte address of the first instruction after reset
//   B_TYPE_BEQ/BNE   : conditional-branch codes shared with decode
//   fe_state_t       : fetch FSM encoding (BOOT / SEQ / DELAY)
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    localparam logic [3:0] B_TYPE_BEQ = 4'b0001;
    localparam logic [3:0] B_TYPE_BNE = 4'b0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        SEQ   = 2'd1,
        DELAY = 2'd2
    } fe_state_t;

endpackage

// File: rtl/fetch_stage_branch_unit.sv
// -----------------------------------------------------------------------------
// branch_unit
// Purely combinational redirect resolution for the fetch stage.
// Ports:
//   i_is_b / i_is_j / i_is_jr : transfer kind held in decode
//   i_b_type                  : B_TYPE_BEQ or B_TYPE_BNE
//   i_b_offset                : signed branch offset in words
//   i_j_index                 : 26-bit jump index
//   i_pc_plus4                : address following the transfer instruction
//   i_rs_value / i_rt_value   : forwarded operands
//   o_taken                   : a control transfer is requested
//   o_target                  : destination, priority J > JR > branch
// -----------------------------------------------------------------------------
module branch_unit
    import fetch_pkg::*;
(
    input  logic        i_is_b,
    input  logic        i_is_j,
    input  logic        i_is_jr,
    input  logic [3:0]  i_b_type,
    input  logic [15:0] i_b_offset,
    input  logic [25:0] i_j_index,
    input  logic [31:0] i_pc_plus4,
    input  logic [31:0] i_rs_value,
    input  logic [31:0] i_rt_value,
    output logic        o_taken,
    output logic [31:0] o_target
);

    logic        w_b_cond;
    logic [31:0] w_b_target;
    logic [31:0] w_j_target;

    always_comb begin
        w_b_cond = 1'b0;
        if (i_b_type == B_TYPE_BEQ) begin
            w_b_cond = (i_rs_value == i_rt_value);
        end else if (i_b_type == B_TYPE_BNE) begin
            w_b_cond = (i_rs_value != i_rt_value);
        end
    end

    // Word offset sign-extended and scaled to bytes; sum wraps at 32 bits.
    assign w_b_target = i_pc_plus4 + {{14{i_b_offset[15]}}, i_b_offset, 2'b00};
    assign w_j_target = {i_pc_plus4[31:28], i_j_index, 2'b00};

    assign o_taken = i_is_j | i_is_jr | (i_is_b & w_b_cond);

    always_comb begin
        if (i_is_j) begin
            o_target = w_j_target;
        end else if (i_is_jr) begin
            o_target = i_rs_value;
        end else begin
            o_target = w_b_target;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch for the 5-stage MIPS pipeline. Owns the PC, drives the
// synchronous instruction SRAM (1-cycle read latency), and implements the
// single branch delay slot and decode stall.
// Ports:
//   clk, resetn             : clock (rising edge), async active-low reset
//   inst_sram_en            : SRAM read enable (follows resetn)
//   inst_sram_addr          : SRAM byte address (combinational)
//   inst_sram_rdata         : data for the address of the previous cycle
//   stall                   : decode stall, holds fetch
//   de_is_b/de_is_j/de_is_jr: redirect kind from decode
//   de_b_type, de_b_offset  : branch condition and word offset
//   de_j_index              : jump index
//   de_rs_value/de_rt_value : forwarded operands
//   fe_inst, current_pc     : instruction and its PC, to decode
//   fe_valid                : fe_inst is a real instruction
//   stall_is_b              : one-cycle pulse per accepted transfer
// -----------------------------------------------------------------------------
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_sram_en,
    output logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_rdata,
    input  logic        stall,
    input  logic        de_is_b,
    input  logic        de_is_j,
    input  logic        de_is_jr,
    input  logic [3:0]  de_b_type,
    input  logic [15:0] de_b_offset,
    input  logic [25:0] de_j_index,
    input  logic [31:0] de_rs_value,
    input  logic [31:0] de_rt_value,
    output logic [31:0] fe_inst,
    output logic [31:0] current_pc,
    output logic        fe_valid,
    output logic        stall_is_b
);

    fe_state_t   r_state;
    fe_state_t   w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_target;
    logic        r_valid;
    logic        r_stall_is_b;

    logic [31:0] w_pc_plus4;
    logic        w_taken;
    logic [31:0] w_target;
    logic        w_accept;
    logic        w_pc_load;

    assign w_pc_plus4 = r_pc + 32'd4;

    branch_unit u_branch_unit (
        .i_is_b     (de_is_b),
        .i_is_j     (de_is_j),
        .i_is_jr    (de_is_jr),
        .i_b_type   (de_b_type),
        .i_b_offset (de_b_offset),
        .i_j_index  (de_j_index),
        .i_pc_plus4 (w_pc_plus4),
        .i_rs_value (de_rs_value),
        .i_rt_value (de_rt_value),
        .o_taken    (w_taken),
        .o_target   (w_target)
    );

    // A transfer is only accepted from a valid instruction in SEQ with no
    // stall; while stalled it is simply re-evaluated the next cycle.
    assign w_accept = (r_state == SEQ) && !stall && w_taken && r_valid;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            BOOT:    w_state_next = SEQ;
            SEQ:     if (w_accept) w_state_next = DELAY;
            DELAY:   if (!stall)   w_state_next = SEQ;
            default: w_state_next = BOOT;
        endcase
    end

    // -------------------------------------------------------------- outputs
    // The fetch address is also the PC value of the next cycle, so the same
    // select drives both the SRAM and the PC register.
    always_comb begin
        inst_sram_addr = RESET_PC;
        w_pc_load      = 1'b0;
        case (r_state)
            BOOT: begin
                inst_sram_addr = RESET_PC;
                w_pc_load      = 1'b1;
            end
            SEQ: begin
                inst_sram_addr = stall ? r_pc : w_pc_plus4;
                w_pc_load      = !stall;
            end
            DELAY: begin
                inst_sram_addr = stall ? r_pc : r_target;
                w_pc_load      = !stall;
            end
            default: begin
                inst_sram_addr = RESET_PC;
                w_pc_load      = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pc         <= '0;
            r_target     <= '0;
            r_valid      <= 1'b0;
            r_stall_is_b <= 1'b0;
        end else begin
            r_stall_is_b <= w_accept;
            if (w_pc_load) begin
                r_pc <= inst_sram_addr;
            end
            if (w_accept) begin
                r_target <= w_target;
            end
            if (r_state == BOOT) begin
                r_valid <= 1'b1;
            end
        end
    end

    assign inst_sram_en = resetn;
    assign current_pc   = r_pc;
    assign fe_valid     = r_valid;
    assign fe_inst      = r_valid ? inst_sram_rdata : 32'h0;
    assign stall_is_b   = r_stall_is_b;

endmodule
